// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard scancode decoder: pops bytes from a receiver FIFO, folds
// E0/F0 prefixes into make/break/repeat events and tracks the held key.
module ps2_key_ctrl #(
  parameter int unsigned POP_GAP = 2
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_nextdata_n,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_repeat,
  output logic       key_valid,
  output logic       key_pressed,
  output logic [7:0] press_count,
  output logic       ovf_sticky,
  input  logic       ovf_clr
);

  localparam int unsigned CODE_W = 8;
  localparam int unsigned GAP_W  = 4;
  localparam int unsigned KEY_W  = CODE_W + 1;

  localparam logic [CODE_W-1:0] BYTE_EXT = 8'hE0;
  localparam logic [CODE_W-1:0] BYTE_BRK = 8'hF0;
  localparam logic [CODE_W-1:0] BYTE_NUL = 8'h00;
  localparam logic [CODE_W-1:0] BYTE_ERR = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e              state_q,    state_d;
  logic [GAP_W-1:0]    gap_cnt_q,  gap_cnt_d;
  logic [CODE_W-1:0]   byte_q,     byte_d;
  logic                ext_pend_q, ext_pend_d;
  logic                brk_pend_q, brk_pend_d;
  logic [KEY_W-1:0]    held_q,     held_d;
  logic                pressed_q,  pressed_d;
  logic [CODE_W-1:0]   code_q,     code_d;
  logic                ext_q,      ext_d;
  logic                brk_q,      brk_d;
  logic                rpt_q,      rpt_d;
  logic                valid_q,    valid_d;
  logic                popn_q,     popn_d;
  logic [CODE_W-1:0]   count_q,    count_d;
  logic                ovf_q,      ovf_d;
  logic                key_hit;

  // Next-state, decode and output logic; every _d defaults to hold.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    byte_d     = byte_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    held_d     = held_q;
    pressed_d  = pressed_q;
    code_d     = code_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    rpt_d      = rpt_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    popn_d     = 1'b1;
    key_hit    = pressed_q && (held_q == {ext_pend_q, byte_q});

    unique case (state_q)
      ST_IDLE: begin
        if (kb_ready) begin
          byte_d  = kb_data;
          popn_d  = 1'b0;
          state_d = ST_POP;
        end
      end

      ST_POP: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
        if (byte_q == BYTE_EXT) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == BYTE_BRK) begin
          brk_pend_d = 1'b1;
        end else if (byte_q == BYTE_NUL || byte_q == BYTE_ERR) begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else begin
          valid_d    = 1'b1;
          code_d     = byte_q;
          ext_d      = ext_pend_q;
          brk_d      = brk_pend_q;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          if (brk_pend_q) begin
            rpt_d = 1'b0;
            if (key_hit) begin
              pressed_d = 1'b0;
            end
          end else if (key_hit) begin
            rpt_d = 1'b1;
          end else begin
            held_d    = {ext_pend_q, byte_q};
            pressed_d = 1'b1;
            rpt_d     = 1'b0;
            count_d   = count_q + CODE_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(POP_GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Overflow set wins over a simultaneous clear.
    if (kb_overflow) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State register; reset aborts any pop/gap sequence in flight.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      byte_q     <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      held_q     <= '0;
      pressed_q  <= 1'b0;
      code_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      rpt_q      <= 1'b0;
      valid_q    <= 1'b0;
      popn_q     <= 1'b1;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      byte_q     <= byte_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      held_q     <= held_d;
      pressed_q  <= pressed_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      rpt_q      <= rpt_d;
      valid_q    <= valid_d;
      popn_q     <= popn_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign kb_nextdata_n = popn_q;
  assign key_code      = code_q;
  assign key_ext       = ext_q;
  assign key_break     = brk_q;
  assign key_repeat    = rpt_q;
  assign key_valid     = valid_q;
  assign key_pressed   = pressed_q;
  assign press_count   = count_q;
  assign ovf_sticky    = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a small receiver-FIFO model.
module tb_ps2_key_ctrl;

  localparam int unsigned POP_GAP = 2;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
    logic       pressed;
    logic [7:0] cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       ovf_clr;
  logic       kb_nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_repeat;
  logic       key_valid;
  logic       key_pressed;
  logic [7:0] press_count;
  logic       ovf_sticky;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model: initial block owns wr, the pop process owns rd.
  logic [7:0] mem [0:4095];
  int         wr = 0;
  int         rd = 0;
  int         nrd;
  int         cyc = 0;
  int         n_pops = 0;
  int         last_pop = 0;
  int         prev_pop = 0;
  ev_t        evq[$];

  ps2_key_ctrl #(.POP_GAP(POP_GAP)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .kb_data      (kb_data),
    .kb_ready     (kb_ready),
    .kb_overflow  (kb_overflow),
    .kb_nextdata_n(kb_nextdata_n),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_break    (key_break),
    .key_repeat   (key_repeat),
    .key_valid    (key_valid),
    .key_pressed  (key_pressed),
    .press_count  (press_count),
    .ovf_sticky   (ovf_sticky),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  // Receiver FIFO: pops on a clock edge that sees the strobe low.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    nrd = rd;
    if (!kb_nextdata_n && rd != wr) begin
      nrd = rd + 1;
      n_pops   <= n_pops + 1;
      prev_pop <= last_pop;
      last_pop <= cyc;
    end
    rd       <= nrd;
    kb_ready <= (nrd != wr);
    kb_data  <= mem[nrd[11:0]];
  end

  // Event capture.
  always @(negedge clk) begin
    if (key_valid)
      evq.push_back('{key_code, key_ext, key_break, key_repeat, key_pressed, press_count});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ev_t get_ev(input int idx);
    if (idx < evq.size()) return evq[idx];
    return '0;
  endfunction

  function automatic logic [22:0] outs();
    return {kb_nextdata_n, key_valid, key_code, key_ext, key_break, key_repeat,
            key_pressed, press_count, ovf_sticky};
  endfunction

  task automatic push(input logic [7:0] b);
    mem[wr[11:0]] = b;
    wr = wr + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    clrn = 1'b0;
  endtask

  // Wait for the FIFO to drain and the last byte's gap to finish.
  task automatic wait_done(input string tag, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rd == wr && kb_nextdata_n) break;
    end
    if (i == limit) chk({tag, "_timeout"}, 32'd1, 32'd0);
    repeat (POP_GAP + 3) @(negedge clk);
  endtask

  initial begin
    int eb;
    int pb;
    int found;
    clrn        = 1'b1;
    kb_overflow = 1'b0;
    ovf_clr     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'h400000);
    clrn = 1'b0;

    // Make, release of 1C.
    eb = evq.size(); pb = n_pops;
    push(8'h1C); push(8'hF0); push(8'h1C);
    wait_done("t21", 200);
    chk("t21_nev",  evq.size() - eb, 2);
    chk("t21_ev0",  32'(get_ev(eb)),     32'({8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01}));
    chk("t21_ev1",  32'(get_ev(eb + 1)), 32'({8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01}));
    chk("t21_pops", n_pops - pb, 3);
    chk("t21_spacing", last_pop - prev_pop, 2 + POP_GAP);

    // Extended make and release.
    do_reset();
    eb = evq.size(); pb = n_pops;
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    wait_done("t22", 200);
    chk("t22_nev",  evq.size() - eb, 2);
    chk("t22_ev0",  32'(get_ev(eb)),     32'({8'h75, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01}));
    chk("t22_ev1",  32'(get_ev(eb + 1)), 32'({8'h75, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01}));
    chk("t22_pops", n_pops - pb, 5);

    // Typematic repeat, discarded 00 clearing a prefix, non-matching break.
    do_reset();
    eb = evq.size();
    push(8'h1C); push(8'h1C); push(8'h1C);
    push(8'hE0); push(8'h00); push(8'h1C);
    push(8'hF0); push(8'h32);
    wait_done("t23", 300);
    chk("t23_nev", evq.size() - eb, 5);
    chk("t23_ev0", 32'(get_ev(eb)),     32'({8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01}));
    chk("t23_ev1", 32'(get_ev(eb + 1)), 32'({8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01}));
    chk("t23_ev2", 32'(get_ev(eb + 2)), 32'({8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01}));
    chk("t23_ev3", 32'(get_ev(eb + 3)), 32'({8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01}));
    chk("t23_ev4", 32'(get_ev(eb + 4)), 32'({8'h32, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01}));
    chk("t23_hold", 32'({key_code, key_break, key_pressed, key_valid}),
        32'({8'h32, 1'b1, 1'b1, 1'b0}));

    // Reset during POP of 1C aborts it; byte is re-read afterwards.
    eb = evq.size(); pb = n_pops;
    push(8'h1C);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!kb_nextdata_n) begin found = 1; break; end
    end
    chk("t26_found_pop", found, 1);
    clrn = 1'b1;
    #1;
    chk("t26_async", 32'({kb_nextdata_n, key_valid}), 32'(2'b10));
    repeat (2) @(negedge clk);
    chk("t26_reset_outs", 32'(outs()), 32'h400000);
    chk("t26_no_ev", evq.size() - eb, 0);
    clrn = 1'b0;
    wait_done("t26", 100);
    chk("t26_nev",  evq.size() - eb, 1);
    chk("t26_ev0",  32'(get_ev(eb)), 32'({8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01}));
    chk("t26_pops", n_pops - pb, 1);

    // 256 distinct make/break pairs wrap the press counter.
    do_reset();
    eb = evq.size();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = 8'h01 + 8'(i % 128);
      if (i >= 128) begin
        push(8'hE0); push(c); push(8'hE0); push(8'hF0); push(c);
      end else begin
        push(c); push(8'hF0); push(c);
      end
    end
    wait_done("t24", 20000);
    chk("t24_nev",     evq.size() - eb, 512);
    chk("t24_cnt_ff",  32'(get_ev(eb + 509).cnt), 32'hFF);
    chk("t24_count",   32'(press_count), 32'h00);
    chk("t24_pressed", 32'(key_pressed), 32'd0);

    // Overflow set beats clear in the same cycle.
    @(negedge clk);
    kb_overflow = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    chk("t25_set_wins", 32'(ovf_sticky), 32'd1);
    kb_overflow = 1'b0;
    @(negedge clk);
    chk("t25_clear", 32'(ovf_sticky), 32'd0);
    ovf_clr = 1'b0;
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    repeat (2) @(negedge clk);
    chk("t25_sticky", 32'(ovf_sticky), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
